// File: rtl/la_pll_pkg.sv
// la_pll_pkg: shared constants for the behavioural PLL model.
//   DIV_W    - width of the output divider counter
//   MAX_ODIV - largest divide ratio the divider counter can hold
package la_pll_pkg;
    localparam int DIV_W    = 10;
    localparam int MAX_ODIV = (1 << DIV_W) - 1;
endpackage

// File: rtl/la_pll_odiv.sv
// la_pll_odiv: enable-gated integer clock divider, registered output.
//   clk   - input clock (rising edge)
//   rst_n - asynchronous active-low reset
//   en    - advances the divider when high
//   clk_o - divided clock, high for ODIV/2 cycles then low for the rest
module la_pll_odiv
    import la_pll_pkg::*;
#(
    parameter int ODIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic clk_o
);
    localparam int HALF = ODIV / 2;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(ODIV - 1);
    localparam logic [DIV_W-1:0] HIGH = DIV_W'(HALF);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            clk_o   <= 1'b0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
            // odd ratios give the extra cycle to the low phase
            clk_o   <= div_cnt < HIGH;
        end
    end
endmodule

// File: rtl/la_pll.sv
// la_pll: behavioural PLL model; locks after LOCK_CYCLES input edges,
// then drives an integer-divided copy of the input clock.
//   clkin1   - reference clock, only clock of the block
//   rst_n    - asynchronous active-low reset
//   clkout0  - divided output clock (ODIV input periods), registered
//   pll_lock - sticky lock indicator, registered
module la_pll
    import la_pll_pkg::*;
#(
    parameter real CLKIN_FREQ  = 148.5,
    parameter int  LOCK_CYCLES = 1024,
    parameter int  ODIV        = 2
) (
    input  logic clkin1,
    input  logic rst_n,
    output logic clkout0,
    output logic pll_lock
);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LAST = LOCK_W'(LOCK_CYCLES - 1);

    generate
        if (ODIV < 2 || ODIV > MAX_ODIV)
            $error("la_pll: ODIV must be 2..%0d", MAX_ODIV);
        if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535)
            $error("la_pll: LOCK_CYCLES must be 1..65535");
        if (CLKIN_FREQ <= 0.0)
            $error("la_pll: CLKIN_FREQ must be positive");
    endgenerate

    logic [LOCK_W-1:0] lock_cnt;

    // counter holds at LAST so it never wraps once locked
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            pll_lock <= 1'b0;
        end else if (!pll_lock) begin
            lock_cnt <= (lock_cnt == LAST) ? lock_cnt : lock_cnt + 1'b1;
            pll_lock <= lock_cnt == LAST;
        end
    end

    la_pll_odiv #(.ODIV(ODIV)) u_odiv0 (
        .clk   (clkin1),
        .rst_n (rst_n),
        .en    (pll_lock),
        .clk_o (clkout0)
    );
endmodule

// File: tb/tb_la_pll.sv
// tb_la_pll: directed bench for la_pll with three parameter sets sharing
// one clock and reset: default, LOCK_CYCLES=1/ODIV=3, LOCK_CYCLES=1/ODIV=1023.
module tb_la_pll;
    logic clkin1 = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_a, lock_a, clk_b, lock_b, clk_c, lock_c;
    bit   bclk, s1, s2, s3;
    int   pulses, errors, checks;
    logic a_bad, a_drop;
    logic [5:0] b_pat;
    int   c_high, n_rise;
    logic prev;
    realtime t0, t1;

    la_pll dut_a (.clkin1(clkin1), .rst_n(rst_n), .clkout0(clk_a), .pll_lock(lock_a));
    la_pll #(.LOCK_CYCLES(1), .ODIV(3)) dut_b (
        .clkin1(clkin1), .rst_n(rst_n), .clkout0(clk_b), .pll_lock(lock_b));
    la_pll #(.LOCK_CYCLES(1), .ODIV(1023)) dut_c (
        .clkin1(clkin1), .rst_n(rst_n), .clkout0(clk_c), .pll_lock(lock_c));

    always #3.367ns clkin1 = ~clkin1;
    always #5ns bclk = ~bclk;

    // free-running observer: counts synchronised rising edges of lock_a
    always @(posedge bclk) begin
        s1 <= lock_a;
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) pulses <= pulses + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clkin1);
        #1ns;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #5ns;
        check("reset_lock_a", lock_a, 0);
        check("reset_clk_a", clk_a, 0);
        check("reset_lock_b", lock_b, 0);
        check("reset_clk_c", clk_c, 0);
        #15ns rst_n = 1'b1;

        step(1);
        check("b_lock_e1", lock_b, 1);
        check("b_clk_e1", clk_b, 0);
        check("a_lock_e1", lock_a, 0);
        step(1);
        check("b_clk_e2", clk_b, 1);
        check("c_clk_e2", clk_c, 1);
        a_bad = lock_a | clk_a;
        c_high = 1;
        b_pat = '0;
        for (int e = 3; e <= 1023; e++) begin
            step(1);
            a_bad |= lock_a | clk_a;
            c_high += int'(clk_c);
            if (e <= 8) b_pat = {b_pat[4:0], clk_b};
        end
        check("a_prelock_low", a_bad, 0);
        check("b_pattern_e3_e8", b_pat, 6'b001001);
        check("c_high_cycles", c_high, 511);
        check("c_clk_e1023", clk_c, 0);

        step(1);
        check("a_lock_e1024", lock_a, 1);
        check("a_clk_e1024", clk_a, 0);
        check("c_clk_e1024", clk_c, 0);
        step(1);
        check("a_clk_e1025", clk_a, 1);
        check("c_clk_wrap_e1025", clk_c, 1);
        step(1);
        check("a_clk_e1026", clk_a, 0);

        n_rise = 0;
        prev = clk_a;
        for (int i = 0; i < 8 && n_rise < 2; i++) begin
            step(1);
            if (!prev && clk_a) begin
                if (n_rise == 0) t0 = $realtime;
                else t1 = $realtime;
                n_rise++;
            end
            prev = clk_a;
        end
        check("a_rises_found", n_rise, 2);
        check("a_period_13p468ns", ((t1 - t0) > 13.467ns && (t1 - t0) < 13.469ns), 1);

        a_drop = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            step(1);
            a_drop |= ~lock_a;
        end
        check("a_lock_sticky", a_drop, 0);
        check("a_lock_pulses_1", pulses, 1);

        step(1);
        if (!clk_a) step(1);
        check("a_clk_before_reset", clk_a, 1);
        rst_n = 1'b0;
        #1ns;
        check("a_lock_async_clear", lock_a, 0);
        check("a_clk_async_clear", clk_a, 0);
        check("c_lock_async_clear", lock_c, 0);
        #9ns rst_n = 1'b1;

        a_bad = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            step(1);
            a_bad |= lock_a | clk_a;
        end
        check("a_relock_prelock_low", a_bad, 0);
        step(1);
        check("a_relock_e1024", lock_a, 1);
        step(1);
        check("a_relock_clk_e1025", clk_a, 1);
        step(10);
        check("a_lock_pulses_2", pulses, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
